// File: rtl/conv_window_sequencer_pkg.sv
// conv_pkg: shared widths, kernel-select and sequencer state types for the 3x3 convolution front end.
package conv_pkg;
  localparam int PIX_W = 8;
  localparam int WIN_N = 9;
  typedef enum logic [1:0] {KSEL_CLEAR = 2'd0, KSEL_SOBX = 2'd1, KSEL_SOBY = 2'd2, KSEL_BLUR = 2'd3} ksel_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_e;
endpackage

// File: rtl/conv_window_sequencer_line_buffer.sv
// conv_line_buffer: two-row pixel store; reads return pre-write contents, a write ages row B into row A.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(IMG_W)-1:0] addr_i,
  input  logic [PIX_W-1:0]         wr_data_i,
  output logic [PIX_W-1:0]         rd_a_o,
  output logic [PIX_W-1:0]         rd_b_o
);
  logic [PIX_W-1:0] row_a_q [IMG_W];
  logic [PIX_W-1:0] row_b_q [IMG_W];
  assign rd_a_o = row_a_q[addr_i];
  assign rd_b_o = row_b_q[addr_i];
  always_ff @(posedge clk) begin
    if (we_i) begin
      row_a_q[addr_i] <= row_b_q[addr_i];
      row_b_q[addr_i] <= wr_data_i;
    end
  end
endmodule

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: streams a raster frame into 3x3 windows for the convolution datapath.
// Optional CONV_FRAME_CNT_EN adds a 16-bit completed-frame counter; otherwise frame_count is 0.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [1:0]             kernel_sel_in,
  input  logic                   pix_valid,
  input  logic [PIX_W-1:0]       pix_data,
  output logic                   pix_ready,
  output logic [WIN_N*PIX_W-1:0] window,
  output logic [1:0]             kernel_sel,
  output logic                   conv_ena,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            frame_count
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  state_e                 state_q;
  ksel_e                  ksel_q;
  logic [CW-1:0]          col_q;
  logic [RW-1:0]          row_q;
  logic [WIN_N*PIX_W-1:0] win_q, win_d;
  logic                   conv_ena_q, out_valid_q;
  logic [PIX_W-1:0]       new_col [3];
  logic                   acc, col_wrap, row_wrap;
  assign acc      = pix_valid && state_q == ST_RUN;
  assign col_wrap = col_q == CW'(IMG_W - 1);
  assign row_wrap = row_q == RW'(IMG_H - 1);
  conv_line_buffer #(.IMG_W(IMG_W)) u_lb (
    .clk      (clk),
    .we_i     (acc),
    .addr_i   (col_q),
    .wr_data_i(pix_data),
    .rd_a_o   (new_col[0]),
    .rd_b_o   (new_col[1])
  );
  assign new_col[2] = pix_data;
  // Each window row shifts toward column 0; the newest column enters at column 2.
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 3; r++) begin
      win_d[PIX_W*(3*r)+:PIX_W]   = win_q[PIX_W*(3*r+1)+:PIX_W];
      win_d[PIX_W*(3*r+1)+:PIX_W] = win_q[PIX_W*(3*r+2)+:PIX_W];
      win_d[PIX_W*(3*r+2)+:PIX_W] = new_col[r];
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ksel_q      <= KSEL_CLEAR;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      conv_ena_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      conv_ena_q  <= acc && row_q >= RW'(2) && col_q >= CW'(2);
      out_valid_q <= conv_ena_q;
      if (acc) begin
        win_q <= win_d;
        col_q <= col_wrap ? '0 : col_q + 1'b1;
        if (col_wrap) row_q <= row_wrap ? '0 : row_q + 1'b1;
      end
      case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_RUN;
          ksel_q  <= ksel_e'(kernel_sel_in);
          col_q   <= '0;
          row_q   <= '0;
        end
        ST_RUN:   if (acc && col_wrap && row_wrap) state_q <= ST_FLUSH;
        ST_FLUSH: state_q <= ST_DONE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end
  assign pix_ready  = state_q == ST_RUN;
  assign busy       = state_q != ST_IDLE;
  assign frame_done = state_q == ST_DONE;
  assign window     = win_q;
  assign kernel_sel = ksel_q;
  assign conv_ena   = conv_ena_q;
  assign out_valid  = out_valid_q;
`ifdef CONV_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk) begin
    if (!resetn) frame_cnt_q <= '0;
    else if (state_q == ST_DONE) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_count = frame_cnt_q;
`else
  assign frame_count = '0;
`endif
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: scoreboard bench; driver queues expected windows, negedge monitors check them.
module tb_conv_window_sequencer;
  logic        clk = 1'b0;
  logic        resetn, start, pix_valid;
  logic [1:0]  kernel_sel_in;
  logic [7:0]  pix_data;
  logic        pix_ready, conv_ena, out_valid, busy, frame_done;
  logic [71:0] window;
  logic [1:0]  kernel_sel;
  logic [15:0] frame_count;
  logic        b_start, b_pix_valid, b_pix_ready, b_conv_ena, b_out_valid, b_busy, b_frame_done;
  logic [71:0] b_window;
  logic [1:0]  b_kernel_sel;
  logic [15:0] b_frame_count;
  int checks = 0, failures = 0;
  logic [71:0] exp_q[$];
  logic [71:0] got;
  logic [1:0]  exp_ksel = 2'd1;
  bit mon_on = 0, lat_chk = 0, busy_p = 0, acc_p = 0, ov_exp = 0;
  int since = 0, ce_cnt = 0, ov_cnt = 0, fd_cnt = 0, frames = 0;
  int b_ov = 0, b_fd = 0;
  always #5 clk = ~clk;
  conv_window_sequencer #(.IMG_W(4), .IMG_H(4)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .kernel_sel_in(kernel_sel_in),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready), .window(window),
    .kernel_sel(kernel_sel), .conv_ena(conv_ena), .out_valid(out_valid), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );
  conv_window_sequencer #(.IMG_W(64), .IMG_H(64)) u_big (
    .clk(clk), .resetn(resetn), .start(b_start), .kernel_sel_in(kernel_sel_in),
    .pix_valid(b_pix_valid), .pix_data(8'h80), .pix_ready(b_pix_ready), .window(b_window),
    .kernel_sel(b_kernel_sel), .conv_ena(b_conv_ena), .out_valid(b_out_valid), .busy(b_busy),
    .frame_done(b_frame_done), .frame_count(b_frame_count)
  );
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic [71:0] win_of(input logic [7:0] base, input int r, input int c);
    logic [71:0] w;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w[8*(3*rr+cc)+:8] = base + 8'((r - 2 + rr) * 4 + (c - 2 + cc));
    return w;
  endfunction
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix_ready"}, 72'(pix_ready), 72'd0);
    chk({tag, "_busy"}, 72'(busy), 72'd0);
    chk({tag, "_window"}, window, 72'd0);
    chk({tag, "_kernel_sel"}, 72'(kernel_sel), 72'd0);
    chk({tag, "_conv_ena"}, 72'(conv_ena), 72'd0);
    chk({tag, "_out_valid"}, 72'(out_valid), 72'd0);
    chk({tag, "_frame_done"}, 72'(frame_done), 72'd0);
    chk({tag, "_frame_count"}, 72'(frame_count), 72'd0);
  endtask
  // Small-frame monitor: pops the scoreboard on every conv_ena and tracks the out_valid pipeline.
  always @(negedge clk) begin
    if (mon_on) begin
      since = (busy && !busy_p) ? 1 : since + 1;
      busy_p = busy;
      chk("out_valid_pipe", 72'(out_valid), 72'(ov_exp));
      ov_exp = conv_ena && resetn;
      if (conv_ena) begin
        ce_cnt++;
        chk("ena_after_accept", 72'(acc_p), 72'd1);
        chk("ksel_during_frame", 72'(kernel_sel), 72'(exp_ksel));
        if (lat_chk && ce_cnt == 1) chk("first_window_cycle", 72'(since), 72'd12);
        if (exp_q.size() == 0) chk("window_unexpected", window, 72'd0);
        else begin
          got = exp_q.pop_front();
          chk("window", window, got);
        end
      end
      if (out_valid) ov_cnt++;
      if (frame_done) begin
        fd_cnt++;
        chk("out_valid_with_done", 72'(out_valid), 72'd1);
      end
      acc_p = pix_valid && pix_ready && resetn;
    end
  end
  always @(negedge clk) begin
    if (mon_on) begin
      if (b_conv_ena) chk("big_window", b_window, {9{8'h80}});
      if (b_out_valid) b_ov++;
      if (b_frame_done) b_fd++;
    end
  end
  task automatic run_frame(input logic [7:0] base, input bit stall, input bit midchg,
                           input int abort_at, input bit chk_lat);
    @(posedge clk); #1;
    ce_cnt = 0; ov_cnt = 0; fd_cnt = 0; lat_chk = chk_lat; exp_ksel = 2'd1;
    kernel_sel_in = 2'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (stall) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (midchg && i == 5) begin
        kernel_sel_in = 2'd3;
        start = 1'b1;
      end
      pix_valid = 1'b1;
      pix_data = base + 8'(i);
      if (i / 4 >= 2 && i % 4 >= 2) exp_q.push_back(win_of(base, i / 4, i % 4));
      @(posedge clk); #1 start = 1'b0;
      if (i == abort_at) begin
        resetn = 1'b0;
        pix_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("midreset");
        exp_q.delete();
        resetn = 1'b1;
        frames = 0;
        return;
      end
    end
    pix_valid = 1'b0;
    for (int k = 0; k < 20 && fd_cnt == 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("frame_done_pulses", 72'(fd_cnt), 72'd1);
    chk("conv_ena_count", 72'(ce_cnt), 72'd4);
    chk("out_valid_count", 72'(ov_cnt), 72'd4);
    chk("scoreboard_drained", 72'(exp_q.size()), 72'd0);
    chk("kernel_sel_after", 72'(kernel_sel), 72'd1);
    chk("idle_after", 72'(busy), 72'd0);
    frames++;
    kernel_sel_in = 2'd1;
  endtask
  task automatic chk_frame_count();
`ifdef CONV_FRAME_CNT_EN
    chk("frame_count", 72'(frame_count), 72'(frames));
`else
    chk("frame_count", 72'(frame_count), 72'd0);
`endif
  endtask
  initial begin
    resetn = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0; kernel_sel_in = 2'd0;
    b_start = 1'b0; b_pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    mon_on = 1;
    resetn = 1'b1;
    run_frame(8'd0, 1'b0, 1'b0, -1, 1'b1);
    run_frame(8'd0, 1'b1, 1'b0, -1, 1'b0);
    run_frame(8'd20, 1'b0, 1'b1, -1, 1'b0);
    chk_frame_count();
    run_frame(8'd50, 1'b0, 1'b0, 9, 1'b0);
    run_frame(8'd100, 1'b0, 1'b0, -1, 1'b1);
    chk_frame_count();
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    b_pix_valid = 1'b1;
    repeat (4096) @(posedge clk);
    #1 b_pix_valid = 1'b0;
    for (int k = 0; k < 20 && b_fd == 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("big_frame_done", 72'(b_fd), 72'd1);
    chk("big_out_valid_count", 72'(b_ov), 72'd3844);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
